// File: rtl/apb_vec_acc_if.sv
// APB3 signal bundle for apb_vec_acc; the master drives requests, the slave answers.
interface apb_vec_acc_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_vec_acc.sv
// APB-programmed vector engine: R[i] = op(A[i], B[i]) over LEN words, one word per cycle,
// with four independent byte lanes (add, sub, saturating add, low-byte multiply).
module apb_vec_acc_lane (
    input  logic [1:0] mode_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] r_o
);
    logic [8:0] sum;
    logic [7:0] prod_lo;

    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign prod_lo = a_i * b_i;

    always_comb begin
        r_o = sum[7:0];
        case (mode_i)
            2'b00:   r_o = sum[7:0];
            2'b01:   r_o = a_i - b_i;
            2'b10:   r_o = sum[8] ? 8'hFF : sum[7:0];
            default: r_o = prod_lo;
        endcase
    end
endmodule

module apb_vec_acc #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DEPTH          = 64
) (
    input  logic          HCLK,
    input  logic          HRESET,
    apb_vec_acc_if.slave  apb,
    output logic          irq_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic [1:0] mode_q;
    logic       irq_en_q, irq_q;
    logic [8:0] len_q;

    logic [31:0] a_mem [DEPTH];
    logic [31:0] b_mem [DEPTH];
    logic [31:0] r_mem [DEPTH];

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [11:0] addr;
    logic [1:0]  win;
    logic [7:0]  widx;
    logic [IW-1:0] midx, ridx;
    logic        in_range, busy, access, err, wr_ok;
    logic        sel_ctrl, sel_status, sel_len;
    logic        ctrl_wr, status_wr, len_wr, start, abort, r_we;
    logic [8:0]  len_wr_val;
    logic [31:0] rdata, op_a, op_b, op_res;
    logic        unused_lsb;

    assign paddr      = apb.PADDR;
    assign addr       = paddr[11:0];
    assign unused_lsb = ^addr[1:0];
    assign win        = addr[11:10];
    assign widx       = addr[9:2];
    assign midx       = widx[IW-1:0];
    assign ridx       = idx_q[IW-1:0];
    assign in_range   = {24'd0, widx} < 32'(DEPTH);
    assign busy       = (state_q == S_RUN);
    assign access     = apb.PSEL & apb.PENABLE;
    assign sel_ctrl   = (win == 2'd0) && (widx == 8'd0);
    assign sel_status = (win == 2'd0) && (widx == 8'd1);
    assign sel_len    = (win == 2'd0) && (widx == 8'd2);

    // A start that is overridden by abort is not a busy-start error.
    always_comb begin
        err = 1'b0;
        case (win)
            2'd0: begin
                if (sel_ctrl)
                    err = apb.PWRITE & busy & apb.PWDATA[0] & ~apb.PWDATA[4];
                else if (sel_len)
                    err = apb.PWRITE & busy;
                else if (!sel_status)
                    err = 1'b1;
            end
            2'd3:    err = ~in_range | apb.PWRITE;
            default: err = ~in_range | (apb.PWRITE & busy);
        endcase
    end

    always_comb begin
        rdata = '0;
        case (win)
            2'd0: begin
                if (sel_status)   rdata = {30'd0, done_q, busy};
                else if (sel_len) rdata = {23'd0, len_q};
            end
            2'd1:    rdata = a_mem[midx];
            2'd2:    rdata = b_mem[midx];
            default: rdata = r_mem[midx];
        endcase
    end

    assign apb.PRDATA  = (apb.PSEL & ~apb.PWRITE & ~err) ? rdata : '0;
    assign apb.PSLVERR = access & err & ~HRESET;
    assign apb.PREADY  = 1'b1;
    assign irq_o       = irq_q;

    assign wr_ok      = access & apb.PWRITE & ~err;
    assign ctrl_wr    = wr_ok & sel_ctrl;
    assign status_wr  = wr_ok & sel_status;
    assign len_wr     = wr_ok & sel_len;
    assign abort      = ctrl_wr & apb.PWDATA[4];
    assign start      = ctrl_wr & apb.PWDATA[0] & ~apb.PWDATA[4];
    assign len_wr_val = (apb.PWDATA[8:0] > 9'(DEPTH)) ? 9'(DEPTH) : apb.PWDATA[8:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        r_we    = 1'b0;
        if (status_wr && apb.PWDATA[1]) done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_q != 9'd0) begin
                        state_d = S_RUN;
                        idx_d   = 8'd0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    r_we  = 1'b1;
                    idx_d = idx_q + 8'd1;
                    if ({1'b0, idx_q} == len_q - 9'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // mode is frozen while running so a mid-run CTRL write (e.g. abort) cannot
    // change the operation applied to the remaining words.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'd0;
            done_q   <= 1'b0;
            mode_q   <= 2'b00;
            irq_en_q <= 1'b0;
            len_q    <= 9'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            irq_q   <= done_q & irq_en_q;
            if (ctrl_wr) begin
                irq_en_q <= apb.PWDATA[3];
                if (!busy) mode_q <= apb.PWDATA[2:1];
            end
            if (len_wr) len_q <= len_wr_val;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_ok && win == 2'd1) a_mem[midx] <= apb.PWDATA;
        if (wr_ok && win == 2'd2) b_mem[midx] <= apb.PWDATA;
        if (r_we)                 r_mem[ridx] <= op_res;
    end

    assign op_a = a_mem[ridx];
    assign op_b = b_mem[ridx];

    for (genvar l = 0; l < 4; l++) begin : g_lane
        apb_vec_acc_lane u_lane (
            .mode_i (mode_q),
            .a_i    (op_a[8*l +: 8]),
            .b_i    (op_b[8*l +: 8]),
            .r_o    (op_res[8*l +: 8])
        );
    end
endmodule

// File: tb/tb_apb_vec_acc.sv
// Scoreboarded bench for apb_vec_acc: each APB access queues its expected response,
// and a monitor checks it when the access phase completes.
module tb_apb_vec_acc;
    localparam int DEPTH = 64;
    localparam logic [11:0] CTRL = 12'h000, STATUS = 12'h004, LEN = 12'h008;
    localparam logic [11:0] ABASE = 12'h400, BBASE = 12'h800, RBASE = 12'hC00;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    logic irq_o;

    apb_vec_acc_if #(.APB_ADDR_WIDTH(12)) apb ();

    apb_vec_acc #(.APB_ADDR_WIDTH(12), .DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .apb(apb), .irq_o(irq_o)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] a_v [DEPTH];
    logic [31:0] b_v [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference byte-lane operation.
    function automatic logic [31:0] vop(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [7:0]  x, y;
        logic [8:0]  s;
        logic [15:0] p;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            x = a[8*l +: 8];
            y = b[8*l +: 8];
            s = {1'b0, x} + {1'b0, y};
            p = 16'(x) * 16'(y);
            case (m)
                2'b00:   r[8*l +: 8] = s[7:0];
                2'b01:   r[8*l +: 8] = x - y;
                2'b10:   r[8*l +: 8] = (s > 9'd255) ? 8'hFF : s[7:0];
                default: r[8*l +: 8] = p[7:0];
            endcase
        end
        return r;
    endfunction

    always @(negedge HCLK) begin
        exp_t e;
        if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: unexpected access at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_err"}, 32'(apb.PSLVERR), 32'(e.err));
                if (e.chk_data) chk({e.name, "_data"}, apb.PRDATA, e.data);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the access-phase edge.
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err, input string name);
        exp_t e;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata;
        @(posedge HCLK); #1;
        e.name = name; e.data = exp_data; e.err = exp_err; e.chk_data = !wr;
        sbq.push_back(e);
        apb.PENABLE = 1'b1;
        @(posedge HCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] d, input logic err, input string name);
        xfer(1'b1, addr, d, 32'd0, err, name);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input logic err, input string name);
        xfer(1'b0, addr, 32'd0, exp, err, name);
    endtask

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [1:0]  modes [4];
        logic [31:0] r0exp [4];
        logic [31:0] e;
        modes = '{2'b00, 2'b10, 2'b01, 2'b11};
        r0exp = '{32'h02008001, 32'h02FF80FF, 32'h00FE7EFF, 32'h01FF7F80};
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;

        // Reset-state behaviour while HRESET is held.
        repeat (2) @(posedge HCLK); #1;
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_pready", 32'(apb.PREADY), 32'd1);
        rd(STATUS, 32'd0, 1'b0, "rst_status");
        rd(LEN, 32'd0, 1'b0, "rst_len");
        rd(12'h100, 32'd0, 1'b0, "rst_unmapped");
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Single-word run in every mode.
        wr(ABASE, 32'h01FF7F80, 1'b0, "wr_a0");
        wr(BBASE, 32'h01010181, 1'b0, "wr_b0");
        wr(LEN, 32'd1, 1'b0, "wr_len1");
        rd(LEN, 32'd1, 1'b0, "rd_len1");
        for (int m = 0; m < 4; m++) begin
            wr(CTRL, {29'd0, modes[m], 1'b1}, 1'b0, "start1");
            rd(STATUS, 32'd2, 1'b0, "len1_done");
            rd(RBASE, r0exp[m], 1'b0, $sformatf("r0_mode%0d", modes[m]));
            wr(STATUS, 32'd2, 1'b0, "w1c");
            rd(STATUS, 32'd0, 1'b0, "w1c_status");
        end

        // LEN clamp, LEN=0 start, abort in IDLE, misc errors.
        wr(LEN, 32'h1FF, 1'b0, "len_big");
        rd(LEN, 32'd64, 1'b0, "len_clamp");
        wr(LEN, 32'd0, 1'b0, "len0");
        wr(CTRL, 32'h1, 1'b0, "start_len0");
        rd(STATUS, 32'd2, 1'b0, "len0_done");
        rd(RBASE, 32'h01FF7F80, 1'b0, "len0_r0_kept");
        wr(STATUS, 32'd2, 1'b0, "w1c2");
        wr(CTRL, 32'h10, 1'b0, "abort_idle");
        rd(STATUS, 32'd0, 1'b0, "abort_idle_st");
        wr(CTRL, 32'h11, 1'b0, "abort_start");
        rd(STATUS, 32'd0, 1'b0, "abort_prio_st");
        wr(RBASE, 32'h12345678, 1'b1, "wr_r_err");
        rd(RBASE, 32'h01FF7F80, 1'b0, "r0_after_err");
        rd(12'h00C, 32'd0, 1'b1, "unmapped_rd");
        wr(12'h100, 32'd5, 1'b1, "unmapped_wr");
        rd(CTRL, 32'd0, 1'b0, "ctrl_rd");

        // 64-word multiply run with interrupt.
        for (int i = 0; i < DEPTH; i++) begin
            a_v[i] = {4{8'(8'h80 + i)}};
            b_v[i] = 32'h90A0B0C0 + 32'(i);
            wr(ABASE + 12'(4*i), a_v[i], 1'b0, "fill_a");
            wr(BBASE + 12'(4*i), b_v[i], 1'b0, "fill_b");
        end
        wr(LEN, 32'd64, 1'b0, "len64");
        wr(CTRL, 32'hF, 1'b0, "start64");
        fork
            begin
                repeat (62) @(posedge HCLK); #1;
                rd(STATUS, 32'd1, 1'b0, "st_busy_last");
                rd(STATUS, 32'd2, 1'b0, "st_done64");
            end
            begin
                repeat (64) @(posedge HCLK); #2;
                chk("irq_before", 32'(irq_o), 32'd0);
                @(posedge HCLK); #2;
                chk("irq_after", 32'(irq_o), 32'd1);
            end
        join
        for (int i = 0; i < DEPTH; i++)
            rd(RBASE + 12'(4*i), vop(2'b11, a_v[i], b_v[i]), 1'b0, $sformatf("r64_%0d", i));
        wr(STATUS, 32'd2, 1'b0, "w1c_irq");
        chk("irq_lag", 32'(irq_o), 32'd1);
        @(posedge HCLK); #1;
        chk("irq_clear", 32'(irq_o), 32'd0);

        // 32-word add run: illegal accesses while busy, then abort with idx=10.
        wr(LEN, 32'd32, 1'b0, "len32");
        wr(CTRL, 32'h1, 1'b0, "start32");
        wr(ABASE, 32'hDEADBEEF, 1'b1, "busy_wr_a");
        wr(CTRL, 32'h1, 1'b1, "busy_start");
        rd(ABASE + 12'(4*DEPTH), 32'd0, 1'b1, "oob_rd");
        wr(LEN, 32'd5, 1'b1, "busy_len");
        @(posedge HCLK); #1;
        wr(CTRL, 32'h10, 1'b0, "abort_run");
        rd(STATUS, 32'd0, 1'b0, "abort_st");
        rd(LEN, 32'd32, 1'b0, "len_kept");
        rd(ABASE, a_v[0], 1'b0, "a0_kept");
        for (int i = 0; i < 32; i++) begin
            e = (i < 10) ? vop(2'b00, a_v[i], b_v[i]) : vop(2'b11, a_v[i], b_v[i]);
            rd(RBASE + 12'(4*i), e, 1'b0, $sformatf("r_abort_%0d", i));
        end

        // Reset in the middle of a run with done and irq set.
        wr(LEN, 32'd0, 1'b0, "len0b");
        wr(CTRL, 32'h9, 1'b0, "start0_irq");
        @(posedge HCLK); #1;
        chk("irq_pre_rst", 32'(irq_o), 32'd1);
        wr(LEN, 32'd32, 1'b0, "len32b");
        wr(CTRL, 32'h9, 1'b0, "start_rst");
        repeat (3) @(posedge HCLK);
        #3 HRESET = 1'b1;
        #1 chk("irq_async_rst", 32'(irq_o), 32'd0);
        @(posedge HCLK); #1;
        rd(STATUS, 32'd0, 1'b0, "rst_mid_status");
        rd(LEN, 32'd0, 1'b0, "rst_mid_len");
        HRESET = 1'b0;
        rd(STATUS, 32'd0, 1'b0, "post_rst_status");
        chk("post_rst_irq", 32'(irq_o), 32'd0);

        repeat (2) @(posedge HCLK);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
